// File: rtl/multi_channel_dac_streamer.sv
// Multi-channel DAC pattern player: per-channel sample tables are replayed as one wide
// AXI-Stream beat per cycle in continuous (HB-resynced), one-shot or burst mode.
module multi_channel_dac_streamer #(
  parameter int NCHANNELS          = 2,
  parameter int SAMPLES_PER_CLOCK  = 8,
  parameter int DAC_DATA_WIDTH     = 16,
  parameter int READ_ADDRESS_WIDTH = 11
) (
  input  logic                                                  axis_CLK,
  input  logic                                                  axis_ARESETN,
  input  logic                                                  wrEnable,
  input  logic [((NCHANNELS > 1) ? $clog2(NCHANNELS) : 1)-1:0]  wrChannel,
  input  logic [READ_ADDRESS_WIDTH+$clog2(SAMPLES_PER_CLOCK)-1:0] wrAddress,
  input  logic [DAC_DATA_WIDTH-1:0]                             wrData,
  input  logic                                                  cfgRun,
  input  logic [1:0]                                            cfgMode,
  input  logic [READ_ADDRESS_WIDTH-1:0]                         cfgLastIdx,
  input  logic [15:0]                                           cfgBurstCount,
  input  logic [NCHANNELS-1:0]                                  cfgChannelEnable,
  input  logic                                                  hbMarker,
  input  logic                                                  trigger,
  output logic [NCHANNELS*SAMPLES_PER_CLOCK*DAC_DATA_WIDTH-1:0] axis_TDATA,
  output logic                                                  axis_TVALID,
  output logic                                                  axis_TLAST,
  input  logic                                                  axis_TREADY,
  output logic                                                  synced,
  output logic [15:0]                                           syncErrorCount,
  output logic                                                  busy
);

  localparam int WA_W  = READ_ADDRESS_WIDTH + $clog2(SAMPLES_PER_CLOCK);
  localparam int DEPTH = 1 << READ_ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_HB = 3'd1,
    S_ARMED   = 3'd2,
    S_PLAY    = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t                        r_state, w_state_nxt;
  logic [READ_ADDRESS_WIDTH-1:0] r_rd_idx, w_rd_idx_nxt, w_rd_step;
  logic [15:0]                   r_pass_cnt, w_pass_nxt, w_pass_target;
  logic                          r_synced, w_synced_nxt;
  logic [15:0]                   r_err_cnt, w_err_nxt;
  logic [1:0]                    r_mode;
  logic [READ_ADDRESS_WIDTH-1:0] r_last_idx;
  logic [15:0]                   r_burst;
  logic                          r_hb_d1, r_hb_d2, r_hb_edge;
  logic [NCHANNELS-1:0]          r_ch_en;
  logic                          r_tvalid, r_tlast;
  logic                          w_advance, w_fetch;

  assign w_advance     = !r_tvalid || axis_TREADY;
  assign w_fetch       = (r_state == S_PLAY);
  assign w_rd_step     = (r_rd_idx == r_last_idx) ? '0 : r_rd_idx + READ_ADDRESS_WIDTH'(1);
  assign w_pass_target = (r_mode == 2'd2 && r_burst != 16'd0) ? r_burst : 16'd1;

  // Config shadows track the inputs only while idle, so they freeze on leaving IDLE.
  always_ff @(posedge axis_CLK or negedge axis_ARESETN) begin
    if (!axis_ARESETN) begin
      r_mode     <= 2'd0;
      r_last_idx <= '0;
      r_burst    <= 16'd0;
      r_ch_en    <= '0;
      r_hb_d1    <= 1'b0;
      r_hb_d2    <= 1'b0;
      r_hb_edge  <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_mode     <= cfgMode;
        r_last_idx <= cfgLastIdx;
        r_burst    <= cfgBurstCount;
      end
      r_ch_en   <= cfgChannelEnable;
      r_hb_d1   <= hbMarker;
      r_hb_d2   <= r_hb_d1;
      r_hb_edge <= r_hb_d1 && !r_hb_d2;
    end
  end

  always_ff @(posedge axis_CLK or negedge axis_ARESETN) begin
    if (!axis_ARESETN) begin
      r_state    <= S_IDLE;
      r_rd_idx   <= '0;
      r_pass_cnt <= 16'd0;
      r_synced   <= 1'b0;
      r_err_cnt  <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_idx   <= w_rd_idx_nxt;
      r_pass_cnt <= w_pass_nxt;
      r_synced   <= w_synced_nxt;
      r_err_cnt  <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_idx_nxt = r_rd_idx;
    w_pass_nxt   = r_pass_cnt;
    w_synced_nxt = r_synced;
    w_err_nxt    = r_err_cnt;
    case (r_state)
      S_IDLE: begin
        if (cfgRun && cfgMode == 2'd0) begin
          w_state_nxt  = S_WAIT_HB;
          w_synced_nxt = 1'b0;
          w_err_nxt    = 16'd0;
        end else if (cfgRun && (cfgMode == 2'd1 || cfgMode == 2'd2)) begin
          w_state_nxt  = S_ARMED;
          w_synced_nxt = 1'b0;
          w_err_nxt    = 16'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_HB, S_ARMED: begin
        if (!cfgRun) begin
          w_state_nxt = S_DRAIN;
        end else if ((r_state == S_WAIT_HB) ? r_hb_edge : trigger) begin
          w_state_nxt  = S_PLAY;
          w_rd_idx_nxt = '0;
          w_pass_nxt   = 16'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_PLAY: begin
        if (r_mode == 2'd0) begin
          // An HB edge that finds the table out of phase wins over the normal step.
          if (r_hb_edge) begin
            w_synced_nxt = (r_rd_idx == '0);
          end else begin
            w_synced_nxt = r_synced;
          end
          if (r_hb_edge && r_rd_idx != '0) begin
            w_rd_idx_nxt = '0;
            w_err_nxt    = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
          end else if (w_advance) begin
            w_rd_idx_nxt = w_rd_step;
          end else begin
            w_rd_idx_nxt = r_rd_idx;
          end
        end else if (w_advance) begin
          w_rd_idx_nxt = w_rd_step;
          if (r_rd_idx == r_last_idx) begin
            w_pass_nxt = r_pass_cnt + 16'd1;
            if (r_pass_cnt + 16'd1 >= w_pass_target) begin
              w_state_nxt = S_ARMED;
            end else begin
              w_state_nxt = S_PLAY;
            end
          end else begin
            w_pass_nxt = r_pass_cnt;
          end
        end else begin
          w_rd_idx_nxt = r_rd_idx;
        end
        if (!cfgRun) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = w_state_nxt;
        end
      end
      S_DRAIN: begin
        if (!r_tvalid) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge axis_CLK or negedge axis_ARESETN) begin
    if (!axis_ARESETN) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_advance) begin
      r_tvalid <= w_fetch;
      r_tlast  <= w_fetch && (r_rd_idx == r_last_idx);
    end else begin
      r_tvalid <= r_tvalid;
      r_tlast  <= r_tlast;
    end
  end

  for (genvar c = 0; c < NCHANNELS; c++) begin : g_ch
    logic [DAC_DATA_WIDTH-1:0] r_mem [0:DEPTH*SAMPLES_PER_CLOCK-1];

    always_ff @(posedge axis_CLK) begin
      if (wrEnable && int'(wrChannel) == c) begin
        r_mem[wrAddress] <= wrData;
      end
    end

    for (genvar j = 0; j < SAMPLES_PER_CLOCK; j++) begin : g_lane
      logic [WA_W-1:0]           w_rd_addr;
      logic [DAC_DATA_WIDTH-1:0] r_lane;

      assign w_rd_addr = WA_W'(int'(r_rd_idx) * SAMPLES_PER_CLOCK + j);

      always_ff @(posedge axis_CLK or negedge axis_ARESETN) begin
        if (!axis_ARESETN) begin
          r_lane <= '0;
        end else if (w_advance) begin
          r_lane <= r_ch_en[c] ? r_mem[w_rd_addr] : '0;
        end else begin
          r_lane <= r_lane;
        end
      end

      assign axis_TDATA[(c*SAMPLES_PER_CLOCK+j)*DAC_DATA_WIDTH +: DAC_DATA_WIDTH] = r_lane;
    end
  end

  assign axis_TVALID    = r_tvalid;
  assign axis_TLAST     = r_tlast;
  assign synced         = r_synced;
  assign syncErrorCount = r_err_cnt;
  assign busy           = (r_state != S_IDLE);

endmodule
